memory_request_arbiter: RTL and testbench

MEMORY_REQUEST_ARBITER -- requirements
Module: memory_request_arbiter

---
 rtl/memory_request_arbiter.sv | 146 ++++++++++++++
 tb/tb_memory_request_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_request_arbiter.sv
// Arbitrates instruction and data requesters onto one single-port RAM.
// Data has priority, bounded by an anti-starvation streak; each access has a watchdog timeout.
module memory_request_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [7:0] LP_LAST_CYC = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [1:0]        r_dgrants;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;
  logic              r_ramren;
  logic              r_ramwen;
  logic              r_ihit;
  logic              r_dhit;
  logic              r_busy;
  logic              r_err;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;

  logic w_dreq;
  logic w_grant_d;
  logic w_timeout;
  logic w_done;

  // Data wins unless it has already taken two grants in a row past a waiting fetch.
  assign w_dreq    = dREN | dWEN;
  assign w_grant_d = w_dreq && !(iREN && (r_dgrants == 2'd2));
  assign w_timeout = (r_cnt == LP_LAST_CYC);
  assign w_done    = ramready || w_timeout;

  // NOTE: every state element uses <= so all registers update together at the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dgrants <= '0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_store   <= '0;
      r_ramren  <= 1'b0;
      r_ramwen  <= 1'b0;
      r_ihit    <= 1'b0;
      r_dhit    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_iload   <= '0;
      r_dload   <= '0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_addr    <= daddr;
            r_store   <= dstore;
            r_wen     <= dWEN;
            r_ramren  <= !dWEN;
            r_ramwen  <= dWEN;
            r_cnt     <= '0;
            r_dgrants <= iREN ? (r_dgrants + 2'd1) : 2'd0;
            r_busy    <= 1'b1;
            r_state   <= DACC;
          end else if (iREN) begin
            r_addr    <= iaddr;
            r_wen     <= 1'b0;
            r_ramren  <= 1'b1;
            r_ramwen  <= 1'b0;
            r_cnt     <= '0;
            r_dgrants <= 2'd0;
            r_busy    <= 1'b1;
            r_state   <= IACC;
          end
        end
        IACC, DACC: begin
          if (w_done) begin
            r_ramren <= 1'b0;
            r_ramwen <= 1'b0;
            // A ready on the final counted cycle still wins over the timeout.
            if (!ramready) r_err <= 1'b1;
            if (r_state == IACC) begin
              r_iload <= ramready ? ramload : '1;
              r_ihit  <= 1'b1;
            end else begin
              if (!r_wen) r_dload <= ramready ? ramload : '1;
              r_dhit <= 1'b1;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ihit     = r_ihit;
  assign dhit     = r_dhit;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign ramREN   = r_ramren;
  assign ramWEN   = r_ramwen;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_memory_request_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        ihit, dhit, ramREN, ramWEN, busy, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [31:0] ramload;
  logic        ramready;

  int          n_checks = 0;
  int          n_fail = 0;

  // RAM responder configuration
  int          lat_cfg = 1;
  bit          stray_ready = 1'b0;
  bit          rload_en = 1'b0;
  logic [31:0] rload_val = '0;
  int          r_acc;

  memory_request_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready),
    .busy(busy), .err(err)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "simulation did not finish");
  end

  function automatic logic [31:0] load_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F1E_2D3C;
  endfunction

  // Memory with a programmable latency counted from the first cycle of ramREN/ramWEN.
  initial begin
    r_acc    = 0;
    ramready = 1'b0;
    ramload  = '0;
    forever begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        r_acc++;
        ramready = (lat_cfg != 0) && (r_acc == lat_cfg);
      end else begin
        r_acc    = 0;
        ramready = stray_ready;
      end
      ramload = rload_en ? rload_val : load_of(ramaddr);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (ihit || dhit) begin
      check("one_hit_only", 64'(ihit & dhit), 64'(0));
      check("resp_ram_quiet", 64'({ramREN, ramWEN}), 64'(0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({ramREN, ramWEN, ihit, dhit, busy, err}), 64'(0));
    check({tag, "_loads"}, {iload, dload}, 64'(0));
    check({tag, "_ram"}, {ramaddr, ramstore}, 64'(0));
  endtask

  // Leaves the bench just after a rising edge with the DUT idle and requests low.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    stray_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  // Current cycle is cycle 0; returns the cycle number of the hit.
  task automatic wait_hit(input bit scr_i, input bit scr_d, input bit drop,
                          output int hc, output bit gi, output bit gd,
                          output bit c_ren, output bit c_wen, output bit c_busy,
                          output logic [31:0] c_addr, output logic [31:0] c_store,
                          output bit stable);
    hc = -1; gi = 0; gd = 0; stable = 1;
    c_ren = 0; c_wen = 0; c_busy = 0; c_addr = '0; c_store = '0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) begin
        c_ren = ramREN; c_wen = ramWEN; c_busy = busy;
        c_addr = ramaddr; c_store = ramstore;
      end else if ((ramREN || ramWEN) && (ramaddr !== c_addr || ramstore !== c_store)) begin
        stable = 0;
      end
      if (ihit || dhit) begin
        hc = c; gi = ihit; gd = dhit;
        if (drop) begin
          if (ihit) iREN = 1'b0;
          if (dhit) begin dREN = 1'b0; dWEN = 1'b0; end
        end
        break;
      end
      if (scr_i) iaddr = $urandom;
      if (scr_d) begin daddr = $urandom; dstore = $urandom; end
    end
    check("hit_within_bound", 64'(hc > 0), 64'(1));
  endtask

  typedef struct {
    bit          is_d;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] store;
    int          lat;
    logic [31:0] rload;
    int          exp_cyc;
    bit          exp_ren;
    bit          exp_wen;
    logic [31:0] exp_load;
    logic [31:0] exp_other;
    bit          exp_err;
  } vec_t;

  vec_t vecs [9];

  function automatic string nm(input int idx, input string s);
    return $sformatf("v%0d_%s", idx, s);
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int hc; bit gi, gd, cr, cw, cb, st; logic [31:0] ca, cs;
    do_reset();
    rload_en = 1; rload_val = v.rload; lat_cfg = v.lat;
    if (v.is_d) begin
      dREN = v.ren; dWEN = v.wen; daddr = v.addr; dstore = v.store;
    end else begin
      iREN = 1'b1; iaddr = v.addr;
    end
    wait_hit(!v.is_d, v.is_d, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
    check(nm(idx, "hit_cycle"), 64'(hc), 64'(v.exp_cyc));
    check(nm(idx, "hit_kind"), 64'({gi, gd}), 64'(v.is_d ? 2'b01 : 2'b10));
    check(nm(idx, "strobes"), 64'({cb, cr, cw}), 64'({1'b1, v.exp_ren, v.exp_wen}));
    check(nm(idx, "ramaddr"), 64'(ca), 64'(v.addr));
    if (v.exp_wen) check(nm(idx, "ramstore"), 64'(cs), 64'(v.store));
    check(nm(idx, "latched"), 64'(st), 64'(1));
    check(nm(idx, "load"), 64'(v.is_d ? dload : iload), 64'(v.exp_load));
    check(nm(idx, "other_load"), 64'(v.is_d ? iload : dload), 64'(v.exp_other));
    check(nm(idx, "err"), 64'(err), 64'(v.exp_err));
    tick();
    check(nm(idx, "idle_after"), 64'({busy, ihit, dhit}), 64'(0));
    rload_en = 0;
  endtask

  initial begin
    int hc; bit gi, gd, cr, cw, cb, st; logic [31:0] ca, cs;

    //           is_d ren  wen  addr           store          lat rload          cyc ren  wen  load           other  err
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         3, 32'h3C01_0004, 4, 1'b1, 1'b0, 32'h3C01_0004, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         1, 32'h1234_5678, 2, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 1, 32'hDEAD_BEEF, 2, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0104, 32'h5A5A_5A5A, 2, 32'hDEAD_BEEF, 3, 1'b0, 1'b1, 32'h0,         32'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0088, 32'h0,         4, 32'hCAFE_F00D, 5, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0,         4, 32'h0BAD_F00D, 5, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_008C, 32'h0,         0, 32'h1111_1111, 5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0000_0048, 32'h0,         0, 32'h2222_2222, 5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h0000_0108, 32'h3333_3333, 0, 32'h4444_4444, 5, 1'b0, 1'b1, 32'h0,         32'h0, 1'b1};

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Data write beats a waiting fetch, dload keeps its earlier read value.
    do_reset();
    lat_cfg = 1; dREN = 1'b1; daddr = 32'h300;
    wait_hit(1'b0, 1'b0, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
    tick();
    iREN = 1'b1; iaddr = 32'h40;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hA5A5_A5A5;
    wait_hit(1'b0, 1'b0, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
    check("pri_data_first", 64'({gi, gd}), 64'(2'b01));
    check("pri_dhit_cycle", 64'(hc), 64'(2));
    check("pri_write_strobes", 64'({cr, cw}), 64'(2'b01));
    check("pri_write_bus", {ca, cs}, {32'h100, 32'hA5A5_A5A5});
    check("pri_dload_kept", 64'(dload), 64'(load_of(32'h300)));
    tick();
    check("pri_idle_gap", 64'(busy), 64'(0));
    wait_hit(1'b0, 1'b0, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
    check("pri_then_instr", 64'({gi, gd}), 64'(2'b10));
    check("pri_ihit_cycle", 64'(3 + hc), 64'(5));
    check("pri_iload", 64'(iload), 64'(load_of(32'h40)));

    // Both requesters held continuously: D,D,I,D,D,I.
    do_reset();
    lat_cfg = 1; dREN = 1'b1; daddr = 32'h500; iREN = 1'b1; iaddr = 32'h600;
    for (int g = 0; g < 6; g++) begin
      wait_hit(1'b0, 1'b0, 1'b0, hc, gi, gd, cr, cw, cb, ca, cs, st);
      check($sformatf("order_g%0d", g), 64'({gi, gd}), 64'((g % 3 == 2) ? 2'b10 : 2'b01));
      tick();
    end
    iREN = 1'b0; dREN = 1'b0;
    tick();

    // Timeout: all-ones read data, sticky err that does not block later accesses.
    do_reset();
    lat_cfg = 0; dREN = 1'b1; daddr = 32'h700;
    wait_hit(1'b0, 1'b0, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
    check("to_dhit_cycle", 64'(hc), 64'(5));
    check("to_dload", 64'(dload), 64'(32'hFFFF_FFFF));
    check("to_err", 64'(err), 64'(1));
    tick();
    lat_cfg = 2; dREN = 1'b1; daddr = 32'h704;
    wait_hit(1'b0, 1'b0, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
    check("to_good_cycle", 64'(hc), 64'(3));
    check("to_good_dload", 64'(dload), 64'(load_of(32'h704)));
    check("to_err_sticky", 64'(err), 64'(1));

    // Reset in the middle of a data access.
    do_reset();
    lat_cfg = 0; dREN = 1'b1; daddr = 32'h200;
    tick(); tick();
    RST = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    check("midrst_no_hit", 64'({ihit, dhit}), 64'(0));
    @(negedge CLK);
    RST = 1'b0; lat_cfg = 2;
    wait_hit(1'b0, 1'b0, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
    check("midrst_retry_kind", 64'({gi, gd}), 64'(2'b01));
    check("midrst_retry_cycle", 64'(hc), 64'(3));
    check("midrst_retry_dload", 64'(dload), 64'(load_of(32'h200)));
    check("midrst_retry_err", 64'(err), 64'(0));

    // Stray ramready while idle, then ready on the last allowed cycle.
    do_reset();
    stray_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stray_idle", 64'({busy, ramREN, ramWEN, ihit, dhit}), 64'(0));
    end
    lat_cfg = 4; dREN = 1'b1; daddr = 32'h800;
    wait_hit(1'b0, 1'b0, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
    check("edge_cycle", 64'(hc), 64'(5));
    check("edge_dload", 64'(dload), 64'(load_of(32'h800)));
    check("edge_err", 64'(err), 64'(0));
    tick();
    check("stray_after", 64'({busy, ihit, dhit}), 64'(0));
    stray_ready = 1'b0;

    // Randomized traffic against a transaction-level model.
    begin
      bit i_pend, d_pend, ee;
      int streak, kind;
      logic [31:0] ei, ed, ia, da, ds;
      i_pend = 0; d_pend = 0; ee = 0; streak = 0; kind = 0;
      ei = '0; ed = '0; ia = '0; da = '0; ds = '0;
      do_reset();
      for (int t = 0; t < 200; t++) begin
        bit gdm, tmo;
        int lat, ecyc, r;
        if (!i_pend && $urandom_range(0, 1) == 1) begin
          ia = $urandom; iaddr = ia; iREN = 1'b1; i_pend = 1;
        end
        if (!d_pend && ($urandom_range(0, 1) == 1 || !i_pend)) begin
          da = $urandom; ds = $urandom; kind = $urandom_range(0, 2);
          daddr = da; dstore = ds; dREN = (kind != 1); dWEN = (kind != 0); d_pend = 1;
        end
        gdm = d_pend && !(i_pend && streak >= 2);
        streak = gdm ? (i_pend ? streak + 1 : 0) : 0;
        r = $urandom_range(0, 9);
        lat = (r < 8) ? 1 + (r % 4) : ((r == 8) ? 0 : 6);
        lat_cfg = lat;
        tmo = (lat < 1) || (lat > 4);
        ecyc = tmo ? 5 : lat + 1;
        wait_hit(!gdm, gdm, 1'b1, hc, gi, gd, cr, cw, cb, ca, cs, st);
        check("rnd_kind", 64'({gi, gd}), 64'(gdm ? 2'b01 : 2'b10));
        check("rnd_cycle", 64'(hc), 64'(ecyc));
        check("rnd_addr", 64'(ca), 64'(gdm ? da : ia));
        check("rnd_strobes", 64'({cr, cw}), 64'({!gdm || kind == 0, gdm && kind != 0}));
        if (gdm && kind != 0) check("rnd_store", 64'(cs), 64'(ds));
        check("rnd_latched", 64'(st), 64'(1));
        if (tmo) ee = 1;
        if (gdm) begin
          if (kind == 0) ed = tmo ? 32'hFFFF_FFFF : load_of(da);
        end else begin
          ei = tmo ? 32'hFFFF_FFFF : load_of(ia);
        end
        check("rnd_iload", 64'(iload), 64'(ei));
        check("rnd_dload", 64'(dload), 64'(ed));
        check("rnd_err", 64'(err), 64'(ee));
        i_pend = iREN;
        d_pend = dREN | dWEN;
        tick();
        check("rnd_idle", 64'({busy, ihit, dhit}), 64'(0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
